instruction_fetch: RTL and testbench

Fetch stage of the SCIC CPU, directly downstream of the 32-word instruction ROM. Owns the program counter and drives the ROM address and chip select. Captures each 32-bit instruction word into an instruction register and hands it to decode/execute over a valid/ready handshake. Accepts branch redirects from execute, flushing the held instruction and refetching from the branch target.

---
 rtl/instruction_fetch.sv | 118 +++++++++++
 tb/tb_instruction_fetch.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, drives the instruction ROM, and holds one fetched
// instruction in the IR for decode/execute over a valid/ready handshake.
// Branch redirects from execute flush the IR and refetch from the target.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   run                 fetch enable (0 parks the stage)
//   rom_address         ROM address (the PC register)
//   rom_chip_select     ROM select, high while in FETCH
//   rom_data            ROM word, combinational from rom_address
//   ir_valid/ir_ready   IR handshake to decode/execute
//   ir_opcode           instruction bits [31:28]
//   ir_operand          instruction bits [15:0]
//   ir_pc               address the IR word was fetched from
//   branch_taken        single-cycle redirect pulse from execute
//   branch_target       redirect address
module instruction_fetch #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  run,
    output logic [ADDR_WIDTH-1:0] rom_address,
    output logic                  rom_chip_select,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic                  ir_valid,
    input  logic                  ir_ready,
    output logic [3:0]            ir_opcode,
    output logic [15:0]           ir_operand,
    output logic [ADDR_WIDTH-1:0] ir_pc,
    input  logic                  branch_taken,
    input  logic [ADDR_WIDTH-1:0] branch_target
);

    localparam int unsigned OPC_W = 4;
    localparam int unsigned OPD_W = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic                  cs_q;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  valid_q, valid_d;
    logic [OPC_W-1:0]      opcode_q, opcode_d;
    logic [OPD_W-1:0]      operand_q, operand_d;
    logic [ADDR_WIDTH-1:0] irpc_q, irpc_d;
    logic                  load;

    // Middle instruction bits are not used by this stage.
    logic unused_rom_bits;
    assign unused_rom_bits = ^rom_data[DATA_WIDTH-OPC_W-1:OPD_W];

    // Next-state, PC and IR update; branch beats load and backpressure.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        valid_d   = valid_q;
        opcode_d  = opcode_q;
        operand_d = operand_q;
        irpc_d    = irpc_q;
        load      = 1'b0;

        case (state_q)
            IDLE:    if (run)  state_d = FETCH;
            FETCH:   if (!run) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        load = (state_q == FETCH) && run && !branch_taken && (!valid_q || ir_ready);

        if (branch_taken) begin
            pc_d    = branch_target;
            valid_d = 1'b0;
        end else if (load) begin
            opcode_d  = rom_data[DATA_WIDTH-1 -: OPC_W];
            operand_d = rom_data[OPD_W-1:0];
            irpc_d    = pc_q;
            valid_d   = 1'b1;
            pc_d      = pc_q + ADDR_WIDTH'(1);
        end else if (valid_q && ir_ready) begin
            // Consumed with nothing to replace it: IR contents become don't-care.
            valid_d = 1'b0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cs_q      <= 1'b0;
            pc_q      <= '0;
            valid_q   <= 1'b0;
            opcode_q  <= '0;
            operand_q <= '0;
            irpc_q    <= '0;
        end else begin
            state_q   <= state_d;
            cs_q      <= (state_d == FETCH);
            pc_q      <= pc_d;
            valid_q   <= valid_d;
            opcode_q  <= opcode_d;
            operand_q <= operand_d;
            irpc_q    <= irpc_d;
        end
    end

    assign rom_address     = pc_q;
    assign rom_chip_select = cs_q;
    assign ir_valid        = valid_q;
    assign ir_opcode       = opcode_q;
    assign ir_operand      = operand_q;
    assign ir_pc           = irpc_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed startup/backpressure/branch/wrap/park/
// reset phases plus random traffic, checked against a cycle-level behavioural
// model with a scoreboard of expected transfers.
module tb_instruction_fetch;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;

    logic          clk;
    logic          reset_n;
    logic          run;
    logic [AW-1:0] rom_address;
    logic          rom_chip_select;
    logic [DW-1:0] rom_data;
    logic          ir_valid;
    logic          ir_ready;
    logic [3:0]    ir_opcode;
    logic [15:0]   ir_operand;
    logic [AW-1:0] ir_pc;
    logic          branch_taken;
    logic [AW-1:0] branch_target;

    logic [DW-1:0] rom [32];
    assign rom_data = rom[rom_address];

    instruction_fetch #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .run             (run),
        .rom_address     (rom_address),
        .rom_chip_select (rom_chip_select),
        .rom_data        (rom_data),
        .ir_valid        (ir_valid),
        .ir_ready        (ir_ready),
        .ir_opcode       (ir_opcode),
        .ir_operand      (ir_operand),
        .ir_pc           (ir_pc),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state as of the most recent clock edge.
    bit          m_fetch;
    int          m_pc;
    bit          m_valid;
    int          m_ir_pc;
    logic [31:0] m_ir_word;
    logic [24:0] exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_fetch   = 0;
        m_pc      = 0;
        m_valid   = 0;
        m_ir_pc   = 0;
        m_ir_word = '0;
        exp_q.delete();
    endtask

    // One clock cycle: drive inputs at the falling edge, predict the outcome
    // of the next rising edge, and commit the prediction just after it.
    task automatic step(input bit r, input bit rdy, input bit bt, input int tgt);
        int          n_pc;
        bit          n_valid;
        int          n_ir_pc;
        logic [31:0] n_word;
        @(negedge clk);
        run           = r;
        ir_ready      = rdy;
        branch_taken  = bt;
        branch_target = AW'(tgt);
        n_pc    = m_pc;
        n_valid = m_valid;
        n_ir_pc = m_ir_pc;
        n_word  = m_ir_word;
        if (m_valid && rdy)
            exp_q.push_back({AW'(m_ir_pc), m_ir_word[31:28], m_ir_word[15:0]});
        if (bt) begin
            n_pc    = tgt % 32;
            n_valid = 0;
        end else if (m_fetch && r && (!m_valid || rdy)) begin
            n_ir_pc = m_pc;
            n_word  = rom[m_pc];
            n_valid = 1;
            n_pc    = (m_pc + 1) % 32;
        end else if (m_valid && rdy) begin
            n_valid = 0;
        end
        @(posedge clk);
        #1;
        m_fetch   = r;
        m_pc      = n_pc;
        m_valid   = n_valid;
        m_ir_pc   = n_ir_pc;
        m_ir_word = n_word;
    endtask

    task automatic rand_steps(input int n);
        for (int i = 0; i < n; i++)
            step($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 9) == 0, int'($urandom_range(0, 31)));
    endtask

    // Monitor: per-cycle state comparison and scoreboard pop on every transfer.
    initial begin
        logic [24:0] e;
        forever begin
            @(negedge clk);
            #4;
            chk("ir_valid", 32'(ir_valid), 32'(m_valid));
            chk("rom_address", 32'(rom_address), 32'(m_pc));
            chk("rom_chip_select", 32'(rom_chip_select), 32'(m_fetch));
            if (ir_valid && ir_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_transfer: got pc %0h op %0h opd %0h expected none",
                             ir_pc, ir_opcode, ir_operand);
                end else begin
                    e = exp_q.pop_front();
                    chk("transfer{pc,op,opd}", 32'({ir_pc, ir_opcode, ir_operand}), 32'(e));
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = $urandom;
        rom[0]  = {4'h4, 12'($urandom), 16'h000f};
        rom[1]  = {4'h7, 12'($urandom), 16'h005f};
        rom[2]  = {4'h4, 12'($urandom), 16'h0001};
        rom[3]  = {4'h1, 12'($urandom), 16'h005f};
        rom[20] = {4'h8, 12'($urandom), 16'h0000};
        rom[31] = {4'h0, 12'($urandom), 16'($urandom)};

        reset_n = 1'b0; run = 1'b1; ir_ready = 1'b1;
        branch_taken = 1'b0; branch_target = '0;
        model_reset();

        // Reset and startup.
        @(posedge clk); #1;
        chk("reset_valid", 32'(ir_valid), 0);
        chk("reset_opcode", 32'(ir_opcode), 0);
        chk("reset_operand", 32'(ir_operand), 0);
        chk("reset_ir_pc", 32'(ir_pc), 0);
        chk("reset_cs", 32'(rom_chip_select), 0);
        chk("reset_addr", 32'(rom_address), 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        step(1, 1, 0, 0);
        chk("start_valid_first_edge", 32'(ir_valid), 0);
        chk("start_cs", 32'(rom_chip_select), 1);
        step(1, 1, 0, 0);
        chk("start_w0", 32'({ir_pc, ir_opcode, ir_operand}), 32'({5'd0, 4'h4, 16'h000f}));
        step(1, 1, 0, 0);
        chk("start_w1", 32'({ir_pc, ir_opcode, ir_operand}), 32'({5'd1, 4'h7, 16'h005f}));
        step(1, 1, 0, 0);
        chk("start_w2", 32'({ir_pc, ir_opcode, ir_operand}), 32'({5'd2, 4'h4, 16'h0001}));

        // Backpressure at ir_pc=2.
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0);
            chk("bp_ir", 32'({ir_pc, ir_opcode, ir_operand}), 32'({5'd2, 4'h4, 16'h0001}));
            chk("bp_addr", 32'(rom_address), 3);
            chk("bp_valid", 32'(ir_valid), 1);
        end
        step(1, 1, 0, 0);
        chk("bp_resume", 32'({ir_pc, ir_opcode, ir_operand}), 32'({5'd3, 4'h1, 16'h005f}));

        // Branch from 0x14 back to 0.
        for (int i = 0; i < 40 && m_ir_pc != 20; i++) step(1, 1, 0, 0);
        chk("br_src", 32'({ir_pc, ir_opcode, ir_operand}), 32'({5'h14, 4'h8, 16'h0000}));
        step(1, 1, 1, 0);
        chk("br_bubble", 32'(ir_valid), 0);
        step(1, 1, 0, 0);
        chk("br_target_valid", 32'(ir_valid), 1);
        chk("br_target", 32'({ir_pc, ir_opcode, ir_operand}), 32'({5'd0, 4'h4, 16'h000f}));

        // Wrap-around.
        for (int i = 0; i < 40 && m_ir_pc != 30; i++) step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        chk("wrap_1f", 32'({ir_pc, ir_opcode}), 32'({5'h1f, 4'h0}));
        step(1, 1, 0, 0);
        chk("wrap_00", 32'({ir_pc, ir_opcode, ir_operand}), 32'({5'd0, 4'h4, 16'h000f}));
        step(1, 1, 0, 0);
        chk("wrap_01", 32'(ir_pc), 1);

        // Run deassert with a held instruction.
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("park_cs", 32'(rom_chip_select), 0);
        chk("park_valid", 32'(ir_valid), 1);
        chk("park_ir_pc", 32'(ir_pc), 1);
        step(0, 1, 0, 0);
        chk("park_drained", 32'(ir_valid), 0);
        chk("park_pc", 32'(rom_address), 2);
        step(0, 0, 0, 0);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        chk("park_resume", 32'({ir_valid, ir_pc}), 32'({1'b1, 5'd2}));

        rand_steps(400);

        // Asynchronous reset mid-stream with a live instruction.
        step(1, 1, 0, 0);
        for (int i = 0; i < 10 && !m_valid; i++) step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("mid_pre_valid", 32'(ir_valid), 1);
        #1 reset_n = 1'b0;
        #1;
        chk("mid_valid_async", 32'(ir_valid), 0);
        chk("mid_addr_async", 32'(rom_address), 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        chk("mid_restart", 32'({ir_valid, ir_pc, ir_opcode, ir_operand}),
            32'({1'b1, 5'd0, 4'h4, 16'h000f}));

        rand_steps(200);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        chk("scoreboard_empty", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
